// File: rtl/valu_seq.sv
// valu_seq: runs one vector operation on a single shared 8-bit ALU (alu_8),
// one element per cycle, and returns the packed result over valid/ready.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE, gated by rst)
//   req_ctl             ALU opcode, forwarded unmodified to alu_ctl
//   req_len             active element count, clamped to LANES
//   req_scalar          broadcast element 0 of req_b as every b operand
//   req_a, req_b        packed operand vectors, element i = bits [8i+7:8i]
//   resp_valid/ready    response handshake; resp_data is the packed result
//   busy                high while an operation is in RUN or DONE
//   alu_ctl/a/b         drive the external alu_8
//   alu_out             combinational result from alu_8
module valu_seq #(
  parameter int LANES = 8,
  parameter int LEN_W = $clog2(LANES + 1),
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_ctl,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               req_scalar,
  input  logic [8*LANES-1:0] req_a,
  input  logic [8*LANES-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [8*LANES-1:0] resp_data,
  output logic               busy,
  output logic [3:0]         alu_ctl,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [7:0]         alu_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [IDX_W-1:0] index;
  logic [3:0]       ctl_reg;
  logic [LEN_W-1:0] len_reg;
  logic             scalar_reg;
  logic [7:0]       a_reg   [LANES];
  logic [7:0]       b_reg   [LANES];
  logic [7:0]       res_reg [LANES];

  logic             accept;
  logic             last;
  logic [LEN_W-1:0] len_clamped;

  assign req_ready  = (state == IDLE) & ~rst;
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign accept     = req_valid & req_ready;

  always_comb begin
    len_clamped = req_len;
    if (req_len > LEN_W'(LANES)) len_clamped = LEN_W'(LANES);
  end

  // len_reg is never 0 while in RUN, so len_reg-1 cannot underflow here.
  assign last = (LEN_W'(index) == (len_reg - LEN_W'(1)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = (len_clamped == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Captured request and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index      <= '0;
      ctl_reg    <= '0;
      len_reg    <= '0;
      scalar_reg <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        a_reg[i]   <= '0;
        b_reg[i]   <= '0;
        res_reg[i] <= '0;
      end
    end else begin
      if (state == IDLE && accept) begin
        index      <= '0;
        ctl_reg    <= req_ctl;
        len_reg    <= len_clamped;
        scalar_reg <= req_scalar;
        for (int unsigned i = 0; i < LANES; i++) begin
          a_reg[i]   <= req_a[8*i +: 8];
          b_reg[i]   <= req_b[8*i +: 8];
          // Clearing here keeps lanes at or above len_reg reading as 0.
          res_reg[i] <= '0;
        end
      end else if (state == RUN) begin
        res_reg[index] <= alu_out;
        if (!last) index <= index + IDX_W'(1);
      end
    end
  end

  // ALU drive: operands only in RUN, opcode always reflects ctl_reg
  always_comb begin
    alu_ctl = ctl_reg;
    alu_a   = '0;
    alu_b   = '0;
    if (state == RUN) begin
      alu_a = a_reg[index];
      alu_b = scalar_reg ? b_reg[0] : b_reg[index];
    end
  end

  always_comb begin
    resp_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      resp_data[8*i +: 8] = res_reg[i];
    end
  end

endmodule
